// File: rtl/alu_frame_if.sv
// UART/ALU side-band bundle for the frame controller.
// master: controller side; slave: UART/ALU environment side.
interface alu_frame_if #(
  parameter int NB_DATA   = 8,
  parameter int N_BITS_OP = 6
);
  logic [NB_DATA-1:0]   i_rx_data;
  logic                 i_rx_done;
  logic [NB_DATA-1:0]   i_alu_result;
  logic                 i_tx_done;
  logic [NB_DATA-1:0]   o_alu_a;
  logic [NB_DATA-1:0]   o_alu_b;
  logic [N_BITS_OP-1:0] o_alu_op;
  logic [NB_DATA-1:0]   o_tx_data;
  logic                 o_tx_start;
  logic                 o_busy;
  logic                 o_timeout;
  logic                 o_overrun;

  modport master (
    input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_data,
    output o_tx_start, o_busy, o_timeout, o_overrun
  );

  modport slave (
    output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_data,
    input  o_tx_start, o_busy, o_timeout, o_overrun
  );
endinterface

// File: rtl/alu_frame_controller.sv
// Collects A, B, opcode bytes from UART, runs the ALU and
// sends the result back, with inter-byte timeout and overrun flag.
module alu_frame_controller #(
  parameter int NB_DATA        = 8,
  parameter int N_BITS_OP      = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic         i_clk,
  input logic         i_reset,
  alu_frame_if.master bus
);

  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, WAIT_OP, COMPUTE, SEND, WAIT_TX
  } state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state, state_n;
  logic        rx_d, tx_d;
  logic        rx_rise, tx_rise;
  logic [31:0] idle_cnt;
  logic        ld_a, ld_b, ld_op, ld_tx;
  logic        to_n, drop;

  assign rx_rise = bus.i_rx_done & ~rx_d;
  assign tx_rise = bus.i_tx_done & ~tx_d;

  always_comb begin
    state_n = state;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_op   = 1'b0;
    ld_tx   = 1'b0;
    to_n    = 1'b0;
    drop    = 1'b0;
    unique case (state)
      WAIT_A: begin
        if (rx_rise) begin
          ld_a    = 1'b1;
          state_n = WAIT_B;
        end
      end
      WAIT_B: begin
        if (rx_rise) begin
          ld_b    = 1'b1;
          state_n = WAIT_OP;
        end else if (idle_cnt == TO_LAST) begin
          to_n    = 1'b1;
          state_n = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (rx_rise) begin
          ld_op   = 1'b1;
          state_n = COMPUTE;
        end else if (idle_cnt == TO_LAST) begin
          to_n    = 1'b1;
          state_n = WAIT_A;
        end
      end
      COMPUTE: begin
        ld_tx   = 1'b1;
        drop    = rx_rise;
        state_n = SEND;
      end
      SEND: begin
        drop    = rx_rise;
        state_n = WAIT_TX;
      end
      WAIT_TX: begin
        drop = rx_rise;
        if (tx_rise) state_n = WAIT_A;
      end
      default: state_n = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= WAIT_A;
      rx_d  <= 1'b0;
      tx_d  <= 1'b0;
    end else begin
      state <= state_n;
      rx_d  <= bus.i_rx_done;
      tx_d  <= bus.i_tx_done;
    end
  end

  // Counter only runs while a partial frame is pending.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idle_cnt <= '0;
    end else if (ld_a || ld_b || ld_op) begin
      idle_cnt <= '0;
    end else if (state == WAIT_B || state == WAIT_OP) begin
      idle_cnt <= idle_cnt + 32'd1;
    end else begin
      idle_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bus.o_alu_a   <= '0;
      bus.o_alu_b   <= '0;
      bus.o_alu_op  <= '0;
      bus.o_tx_data <= '0;
      bus.o_timeout <= 1'b0;
      bus.o_overrun <= 1'b0;
    end else begin
      if (ld_a)  bus.o_alu_a   <= bus.i_rx_data;
      if (ld_b)  bus.o_alu_b   <= bus.i_rx_data;
      if (ld_op) bus.o_alu_op  <= bus.i_rx_data[N_BITS_OP-1:0];
      if (ld_tx) bus.o_tx_data <= bus.i_alu_result;
      bus.o_timeout <= to_n;
      if (drop)  bus.o_overrun <= 1'b1;
    end
  end

  assign bus.o_tx_start = (state == SEND);
  assign bus.o_busy     = (state == COMPUTE) ||
                          (state == SEND) ||
                          (state == WAIT_TX);

endmodule

// File: tb/tb_alu_frame_controller.sv
// Directed bench for alu_frame_controller with an adder ALU stub.
module tb_alu_frame_controller;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_frame_if #(.NB_DATA(8), .N_BITS_OP(6)) bus ();

  alu_frame_controller #(
    .NB_DATA(8),
    .N_BITS_OP(6),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus)
  );

  assign bus.i_alu_result = bus.o_alu_a + bus.o_alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
    tick();
  endtask

  task automatic run_op(input logic [7:0] op,
                        input logic [31:0] exp_op,
                        input logic [31:0] exp_tx);
    bus.i_rx_data = op;
    bus.i_rx_done = 1'b1;
    tick();
    chk("op_reg", 32'(bus.o_alu_op), exp_op);
    chk("compute_busy", 32'(bus.o_busy), 1);
    chk("compute_nostart", 32'(bus.o_tx_start), 0);
    bus.i_rx_done = 1'b0;
    tick();
    chk("send_start", 32'(bus.o_tx_start), 1);
    chk("send_data", 32'(bus.o_tx_data), exp_tx);
    tick();
    chk("waittx_nostart", 32'(bus.o_tx_start), 0);
    chk("waittx_busy", 32'(bus.o_busy), 1);
  endtask

  task automatic finish_tx();
    bus.i_tx_done = 1'b1;
    tick();
    chk("tx_done_idle", 32'(bus.o_busy), 0);
    bus.i_tx_done = 1'b0;
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, 32'(bus.o_alu_a), 0);
    chk({tag, "_b"}, 32'(bus.o_alu_b), 0);
    chk({tag, "_op"}, 32'(bus.o_alu_op), 0);
    chk({tag, "_txd"}, 32'(bus.o_tx_data), 0);
    chk({tag, "_start"}, 32'(bus.o_tx_start), 0);
    chk({tag, "_busy"}, 32'(bus.o_busy), 0);
    chk({tag, "_to"}, 32'(bus.o_timeout), 0);
    chk({tag, "_ovr"}, 32'(bus.o_overrun), 0);
  endtask

  initial begin
    bit seen;
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_zero("reset");

    // basic frame, then a byte during WAIT_TX
    send_byte(8'h0A);
    send_byte(8'h05);
    chk("f1_a", 32'(bus.o_alu_a), 32'h0A);
    chk("f1_b", 32'(bus.o_alu_b), 32'h05);
    run_op(8'h20, 32'h20, 32'h0F);
    bus.i_rx_data = 8'h55;
    bus.i_rx_done = 1'b1;
    tick();
    chk("ovr_set", 32'(bus.o_overrun), 1);
    chk("ovr_a_hold", 32'(bus.o_alu_a), 32'h0A);
    bus.i_rx_done = 1'b0;
    tick();
    finish_tx();
    chk("ovr_sticky", 32'(bus.o_overrun), 1);

    // held rx_done is a single event
    bus.i_rx_data = 8'h33;
    bus.i_rx_done = 1'b1;
    repeat (10) tick();
    chk("held_a", 32'(bus.o_alu_a), 32'h33);
    chk("held_b", 32'(bus.o_alu_b), 32'h05);
    chk("held_idle", 32'(bus.o_busy), 0);
    bus.i_rx_done = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bus.o_timeout) seen = 1'b1;
    end
    chk("held_timeout_seen", 32'(seen), 1);
    tick();

    // exact timeout boundary
    send_byte(8'h0A);
    repeat (14) tick();
    chk("to_early", 32'(bus.o_timeout), 0);
    tick();
    chk("to_pulse", 32'(bus.o_timeout), 1);
    chk("to_idle", 32'(bus.o_busy), 0);
    tick();
    chk("to_one_cycle", 32'(bus.o_timeout), 0);
    send_byte(8'h01);
    send_byte(8'h02);
    chk("fresh_a", 32'(bus.o_alu_a), 32'h01);
    chk("fresh_b", 32'(bus.o_alu_b), 32'h02);
    run_op(8'h20, 32'h20, 32'h03);
    finish_tx();

    // byte on the timeout cycle wins; opcode truncation
    send_byte(8'h0A);
    repeat (14) tick();
    bus.i_rx_data = 8'h07;
    bus.i_rx_done = 1'b1;
    tick();
    chk("win_no_to", 32'(bus.o_timeout), 0);
    chk("win_b", 32'(bus.o_alu_b), 32'h07);
    bus.i_rx_done = 1'b0;
    tick();
    run_op(8'hE4, 32'h24, 32'h11);
    finish_tx();

    // reset mid-frame
    send_byte(8'h09);
    send_byte(8'h08);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("midreset");
    send_byte(8'h03);
    send_byte(8'h04);
    run_op(8'h20, 32'h20, 32'h07);
    chk("post_rst_a", 32'(bus.o_alu_a), 32'h03);
    finish_tx();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_frame_controller.md
ALU_FRAME_CONTROLLER -- requirements
Module: alu_frame_controller

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 8, UART byte and ALU operand width.
REQ-002 The block SHALL have parameter N_BITS_OP, default 6, ALU opcode width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, maximum idle clocks between bytes of one frame.
REQ-004 i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 i_reset  input  1  reset, synchronous and active-high.
REQ-006 i_rx_data  input  NB_DATA  received byte from uart_rx.
REQ-007 i_rx_done  input  1  uart_rx byte-complete flag; only its rising edge is used.
REQ-008 i_alu_result  input  NB_DATA  combinational ALU result for the current o_alu_a/o_alu_b/o_alu_op.
REQ-009 i_tx_done  input  1  uart_tx done flag; only its rising edge is used.
REQ-010 o_alu_a  output  NB_DATA  registered operand A.
REQ-011 o_alu_b  output  NB_DATA  registered operand B.
REQ-012 o_alu_op  output  N_BITS_OP  registered opcode, the low N_BITS_OP bits of the third byte.
REQ-013 o_tx_data  output  NB_DATA  registered byte to transmit.
REQ-014 o_tx_start  output  1  one-cycle transmit request to uart_tx.
REQ-015 o_busy  output  1  high in COMPUTE, SEND and WAIT_TX states.
REQ-016 o_timeout  output  1  one-cycle pulse when a partial frame is abandoned.
REQ-017 o_overrun  output  1  sticky flag: a byte arrived while busy.

Function
REQ-018 The block SHALL register i_rx_done and i_tx_done and act on the cycle where the input is 1 and the registered copy is 0 (rise); a held-high flag SHALL count as one event.
REQ-019 States SHALL be WAIT_A, WAIT_B, WAIT_OP, COMPUTE, SEND, WAIT_TX.
REQ-020 WAIT_A on rx rise: o_alu_a <= i_rx_data, go WAIT_B.
REQ-021 WAIT_B on rx rise: o_alu_b <= i_rx_data, go WAIT_OP.
REQ-022 WAIT_OP on rx rise: o_alu_op <= i_rx_data[N_BITS_OP-1:0], go COMPUTE.
REQ-023 COMPUTE SHALL last exactly one cycle; then o_tx_data <= i_alu_result, go SEND.
REQ-024 SEND SHALL last one cycle with o_tx_start = 1, then go WAIT_TX; o_tx_start SHALL be 0 in all other states.
REQ-025 WAIT_TX on tx rise SHALL go WAIT_A; operand/opcode registers SHALL hold their values until overwritten.
REQ-026 Latency: o_tx_start SHALL be high exactly 2 cycles after the cycle the opcode rx rise is sampled.
REQ-027 A 32-bit idle counter SHALL clear on entry to WAIT_B/WAIT_OP and on every accepted byte, and increment each cycle in WAIT_B and WAIT_OP.
REQ-028 When the counter reaches TIMEOUT_CYCLES-1 with no rx rise in that cycle, the block SHALL go WAIT_A and pulse o_timeout for one cycle; an rx rise in that same cycle SHALL win (byte accepted, no timeout).
REQ-029 No timeout SHALL apply in WAIT_A or WAIT_TX.
REQ-030 An rx rise in COMPUTE, SEND or WAIT_TX SHALL be dropped and set o_overrun, which SHALL stay 1 until reset.
REQ-031 Simultaneous rx rise and tx rise in WAIT_TX: tx rise transitions to WAIT_A, the byte SHALL be dropped and o_overrun set.

Reset
REQ-032 While i_reset is high on a rising edge, state SHALL become WAIT_A, all outputs and edge/idle registers 0.
REQ-033 Reset asserted mid-frame or during WAIT_TX SHALL abandon the frame; the next rx rise after release SHALL be taken as operand A.

Verification
REQ-034 Bytes 0x0A, 0x05, 0x20 with ALU stub result 0x0F -> o_alu_a=0x0A, o_alu_b=0x05, o_alu_op=0x20, one-cycle o_tx_start 2 cycles after opcode, o_tx_data=0x0F.
REQ-035 i_rx_done held high 10 cycles with 0x33 -> only o_alu_a=0x33 captured, state WAIT_B.
REQ-036 TIMEOUT_CYCLES=16, send 0x0A then idle -> o_timeout pulse after 16 cycles, next bytes 0x01,0x02,0x20 form a fresh frame with o_alu_a=0x01.
REQ-037 Byte 0x55 sent while in WAIT_TX -> o_overrun=1, o_alu_a unchanged; tx rise returns WAIT_A with o_overrun still 1.
REQ-038 Reset pulse after operand B -> all outputs 0; subsequent 0x03,0x04,0x20 produce o_tx_start with o_alu_a=0x03.
REQ-039 Opcode byte 0xE4 -> o_alu_op=0x24 (upper bits discarded).
